// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: owns the 128-bit state register and steps it
// through AddRoundKey/SubBytes/ShiftRows/MixColumns, one round per clock.
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] plaintext_i,
    output logic [3:0]   round_idx_o,
    input  logic [127:0] round_key_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] ciphertext_o,
    output logic         busy_o
);

    // state | meaning
    // IDLE  | waiting for plaintext
    // INIT  | initial AddRoundKey with key 0
    // ROUND | full rounds 1..NR-1
    // FINAL | last round, no MixColumns
    // DONE  | ciphertext offered until taken
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] NR_L = 4'(NR);

    logic [2:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] sub_w, shift_w, mix_w;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] sq;
        logic [7:0] inv;
        acc = 8'h01;
        sq  = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) acc = gmul(acc, sq);
            sq = gmul(sq, sq);
        end
        inv = acc;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*(((c+r)%4))+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    always_comb begin
        sub_w   = sub_bytes(state_q);
        shift_w = shift_rows(sub_w);
        mix_w   = mix_columns(shift_w);
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d = plaintext_i;
                    rnd_d   = 4'd0;
                    fsm_d   = S_INIT;
                end
            end
            S_INIT: begin
                state_d = state_q ^ round_key_i;
                rnd_d   = 4'd1;
                fsm_d   = S_ROUND;
            end
            S_ROUND: begin
                state_d = mix_w ^ round_key_i;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == NR_L - 4'd1) fsm_d = S_FINAL;
            end
            S_FINAL: begin
                state_d = shift_w ^ round_key_i;
                fsm_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= S_IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        round_idx_o = 4'd0;
        case (fsm_q)
            S_ROUND:         round_idx_o = rnd_q;
            S_FINAL, S_DONE: round_idx_o = NR_L;
            default:         round_idx_o = 4'd0;
        endcase
    end

    // Masking with reset keeps a same-cycle handshake from completing while reset wins.
    assign in_ready_o   = (fsm_q == S_IDLE) && !rst_i;
    assign out_valid_o  = (fsm_q == S_DONE) && !rst_i;
    assign busy_o       = (fsm_q != S_IDLE);
    assign ciphertext_o = state_q;

endmodule
